// File: rtl/axi_lite_to_wb_bridge.sv
// AXI4-Lite slave to Wishbone classic master bridge.
// Only one Wishbone transaction is in flight at a time. AW and W are captured
// into holding registers independently. A fairness flag alternates writes and
// reads when both are pending. Every output is driven from a register.
module axi_lite_to_wb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    // AXI4-Lite write address channel
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    // AXI4-Lite write data channel
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    // AXI4-Lite write response channel
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    // AXI4-Lite read address channel
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    // AXI4-Lite read data channel
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    // Wishbone classic master
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_rty_i
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int TMO_WIDTH  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value seen during the last stb cycle allowed before an abort.
    localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WB_WR,
        WB_RD,
        WR_RESP,
        RD_RESP
    } state_e;

    state_e                  state_q,   state_d;

    // Write holding registers
    logic                    aw_full_q, aw_full_d;
    logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
    logic                    w_full_q,  w_full_d;
    logic [DATA_WIDTH-1:0]   w_data_q,  w_data_d;
    logic [STRB_WIDTH-1:0]   w_strb_q,  w_strb_d;

    // Set after a write completes, cleared after a read completes
    logic                    fair_q,    fair_d;
    logic [TMO_WIDTH-1:0]    tmo_q,     tmo_d;

    // Registered AXI outputs
    logic                    awready_q, awready_d;
    logic                    wready_q,  wready_d;
    logic                    arready_q, arready_d;
    logic                    bvalid_q,  bvalid_d;
    logic [1:0]              bresp_q,   bresp_d;
    logic                    rvalid_q,  rvalid_d;
    logic [1:0]              rresp_q,   rresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;

    // Registered Wishbone outputs
    logic                    cyc_q,     cyc_d;
    logic                    stb_q,     stb_d;
    logic                    we_q,      we_d;
    logic [ADDR_WIDTH-1:0]   adr_q,     adr_d;
    logic [STRB_WIDTH-1:0]   sel_q,     sel_d;
    logic [DATA_WIDTH-1:0]   dat_q,     dat_d;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    ar_hs;
    logic                    tmo_hit;
    logic                    wb_term;
    logic [1:0]              term_resp;

    assign aw_hs   = s_awvalid && awready_q;
    assign w_hs    = s_wvalid  && wready_q;
    assign ar_hs   = s_arvalid && arready_q;
    assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TMO_LAST);
    assign wb_term = wb_ack_i || wb_err_i || wb_rty_i || tmo_hit;

    // Response code for a terminating cycle: err/rty beat ack, timeout is last.
    always_comb begin
        term_resp = RESP_DECERR;
        if (wb_err_i || wb_rty_i) begin
            term_resp = RESP_SLVERR;
        end else if (wb_ack_i) begin
            term_resp = RESP_OKAY;
        end
    end

    // Next-state, holding-register and registered-output computation.
    always_comb begin
        // NOTE: every signal is given its hold value first so that no path
        // through the case statement leaves one unassigned (no latches).
        state_d   = state_q;
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        fair_d    = fair_q;
        tmo_d     = tmo_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        adr_d     = adr_q;
        sel_d     = sel_q;
        dat_d     = dat_q;

        unique case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    aw_full_d = 1'b1;
                    aw_addr_d = s_awaddr;
                end
                if (w_hs) begin
                    w_full_d = 1'b1;
                    w_data_d = s_wdata;
                    w_strb_d = s_wstrb;
                end
                if (aw_full_q && w_full_q) begin
                    state_d = WB_WR;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    adr_d   = aw_addr_q;
                    sel_d   = w_strb_q;
                    dat_d   = w_data_q;
                    tmo_d   = '0;
                end else if (ar_hs) begin
                    state_d = WB_RD;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = 1'b0;
                    adr_d   = s_araddr;
                    sel_d   = '1;
                    dat_d   = '0;
                    tmo_d   = '0;
                end
            end

            WB_WR, WB_RD: begin
                if (wb_term) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    sel_d = '0;
                    dat_d = '0;
                    tmo_d = '0;
                    if (state_q == WB_WR) begin
                        state_d  = WR_RESP;
                        bvalid_d = 1'b1;
                        bresp_d  = term_resp;
                    end else begin
                        state_d  = RD_RESP;
                        rvalid_d = 1'b1;
                        rresp_d  = term_resp;
                        rdata_d  = (term_resp == RESP_OKAY) ? wb_dat_i : '0;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_WIDTH'(1);
                end
            end

            WR_RESP: begin
                if (s_bready) begin
                    state_d   = IDLE;
                    bvalid_d  = 1'b0;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    fair_d    = 1'b1;
                end
            end

            RD_RESP: begin
                if (s_rready) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b0;
                    fair_d   = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Ready flags are registered. They are computed from the next-cycle view,
        // so a register that has just filled never accepts a second beat.
        awready_d = (state_d == IDLE) && !aw_full_d && (!fair_d || !s_arvalid);
        wready_d  = (state_d == IDLE) && !w_full_d  && (!fair_d || !s_arvalid);
        arready_d = (state_d == IDLE) && !aw_full_d && !w_full_d &&
                    (fair_d || (!s_awvalid && !s_wvalid));
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst) begin
            state_q   <= IDLE;
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            fair_q    <= 1'b0;
            tmo_q     <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            sel_q     <= '0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            fair_q    <= fair_d;
            tmo_q     <= tmo_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            sel_q     <= sel_d;
            dat_q     <= dat_d;
        end
    end

    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_arready = arready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_rvalid  = rvalid_q;
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_sel_o  = sel_q;
    assign wb_dat_o  = dat_q;

endmodule

// File: tb/tb_axi_lite_to_wb_bridge.sv
// Directed testbench for axi_lite_to_wb_bridge (TIMEOUT set to 4).
// Inputs are driven 1 time unit after each rising edge, and outputs are checked
// at the same point.
module tb_axi_lite_to_wb_bridge;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [AW-1:0]   s_awaddr;
    logic            s_awvalid;
    logic            s_awready;
    logic [DW-1:0]   s_wdata;
    logic [DW/8-1:0] s_wstrb;
    logic            s_wvalid;
    logic            s_wready;
    logic [1:0]      s_bresp;
    logic            s_bvalid;
    logic            s_bready;
    logic [AW-1:0]   s_araddr;
    logic            s_arvalid;
    logic            s_arready;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rvalid;
    logic            s_rready;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [AW-1:0]   wb_adr_o;
    logic [DW/8-1:0] wb_sel_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_ack_i;
    logic            wb_err_i;
    logic            wb_rty_i;

    int errors = 0;
    int checks = 0;

    axi_lite_to_wb_bridge #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_awaddr (s_awaddr),
        .s_awvalid(s_awvalid),
        .s_awready(s_awready),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_wvalid (s_wvalid),
        .s_wready (s_wready),
        .s_bresp  (s_bresp),
        .s_bvalid (s_bvalid),
        .s_bready (s_bready),
        .s_araddr (s_araddr),
        .s_arvalid(s_arvalid),
        .s_arready(s_arready),
        .s_rdata  (s_rdata),
        .s_rresp  (s_rresp),
        .s_rvalid (s_rvalid),
        .s_rready (s_rready),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_adr_o (wb_adr_o),
        .wb_sel_o (wb_sel_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .wb_rty_i (wb_rty_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the stimulus sequence.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    logic order [0:5];
    int   n_tx;
    int   n_stb;
    logic prev_cyc;
    bit   done;

    initial begin
        rst       = 1'b0;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        wb_dat_i  = '0;
        wb_ack_i  = 1'b0;
        wb_err_i  = 1'b0;
        wb_rty_i  = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick(); tick();
        check("rst_awready", 64'(s_awready), 64'(0));
        check("rst_arready", 64'(s_arready), 64'(0));
        check("rst_bvalid",  64'(s_bvalid),  64'(0));
        check("rst_rvalid",  64'(s_rvalid),  64'(0));
        check("rst_cyc",     64'(wb_cyc_o),  64'(0));
        check("rst_outs",    64'({wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o}), 64'(0));
        rst = 1'b1;
        tick();
        check("idle_awready", 64'(s_awready), 64'(1));
        check("idle_arready", 64'(s_arready), 64'(1));

        // Termination inputs while cyc is low must be ignored.
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        tick();
        check("ign_bvalid", 64'(s_bvalid), 64'(0));
        check("ign_rvalid", 64'(s_rvalid), 64'(0));

        // ---------------- write: AW three cycles before W, ack on 2nd stb cycle ----------------
        s_awaddr  = 32'h0000_1000;
        s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        check("w1_awready_drop", 64'(s_awready), 64'(0));
        check("w1_no_cyc_aw",    64'(wb_cyc_o),  64'(0));
        tick(); tick();
        s_wdata  = 32'hDEAD_BEEF;
        s_wstrb  = 4'hF;
        s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        check("w1_no_cyc_held", 64'(wb_cyc_o), 64'(0));
        tick();
        check("w1_cyc", 64'(wb_cyc_o), 64'(1));
        check("w1_stb", 64'(wb_stb_o), 64'(1));
        check("w1_we",  64'(wb_we_o),  64'(1));
        check("w1_adr", 64'(wb_adr_o), 64'(32'h0000_1000));
        check("w1_sel", 64'(wb_sel_o), 64'(4'hF));
        check("w1_dat", 64'(wb_dat_o), 64'(32'hDEAD_BEEF));
        tick();
        check("w1_stb_cycle2", 64'(wb_stb_o), 64'(1));
        check("w1_no_bvalid",  64'(s_bvalid), 64'(0));
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("w1_cyc_drop", 64'(wb_cyc_o), 64'(0));
        check("w1_idle_outs", 64'({wb_we_o, wb_sel_o, wb_dat_o}), 64'(0));
        check("w1_bvalid",   64'(s_bvalid), 64'(1));
        check("w1_bresp",    64'(s_bresp),  64'(2'b00));
        tick(); tick();
        check("w1_bvalid_hold", 64'(s_bvalid), 64'(1));
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        check("w1_bvalid_clear", 64'(s_bvalid), 64'(0));
        tick();
        check("w1_bvalid_once", 64'(s_bvalid), 64'(0));

        // ---------------- read 0x2004 with ack ----------------
        s_araddr  = 32'h0000_2004;
        s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        check("r1_cyc_next", 64'(wb_cyc_o),  64'(1));
        check("r1_we",       64'(wb_we_o),   64'(0));
        check("r1_adr",      64'(wb_adr_o),  64'(32'h0000_2004));
        check("r1_sel",      64'(wb_sel_o),  64'(4'hF));
        check("r1_arready",  64'(s_arready), 64'(0));
        wb_dat_i = 32'h1234_5678;
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        wb_dat_i = 32'hFFFF_FFFF;
        check("r1_cyc_drop", 64'(wb_cyc_o), 64'(0));
        check("r1_rvalid",   64'(s_rvalid), 64'(1));
        check("r1_rdata",    64'(s_rdata),  64'(32'h1234_5678));
        check("r1_rresp",    64'(s_rresp),  64'(2'b00));
        tick();
        check("r1_rdata_hold", 64'(s_rdata), 64'(32'h1234_5678));
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        check("r1_rvalid_clear", 64'(s_rvalid), 64'(0));

        // ---------------- read terminated with err and ack together ----------------
        s_araddr  = 32'h0000_3000;
        s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        check("r2_cyc", 64'(wb_cyc_o), 64'(1));
        wb_dat_i = 32'hCAFE_F00D;
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        check("r2_rvalid", 64'(s_rvalid), 64'(1));
        check("r2_rresp",  64'(s_rresp),  64'(2'b10));
        check("r2_rdata",  64'(s_rdata),  64'(0));
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;

        // ---------------- write terminated with rty; AW and W together ----------------
        s_awaddr  = 32'h0000_0040;
        s_awvalid = 1'b1;
        s_wdata   = 32'h0000_00AA;
        s_wstrb   = 4'h1;
        s_wvalid  = 1'b1;
        tick();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        tick();
        check("w2_cyc", 64'(wb_cyc_o), 64'(1));
        check("w2_sel", 64'(wb_sel_o), 64'(4'h1));
        check("w2_dat", 64'(wb_dat_o), 64'(32'h0000_00AA));
        wb_rty_i = 1'b1;
        tick();
        wb_rty_i = 1'b0;
        check("w2_bvalid", 64'(s_bvalid), 64'(1));
        check("w2_bresp",  64'(s_bresp),  64'(2'b10));
        check("w2_cyc_drop", 64'(wb_cyc_o), 64'(0));
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;

        // ---------------- read to a silent slave: timeout after 4 stb cycles ----------------
        s_araddr  = 32'h0000_5000;
        s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        n_stb = 0;
        while (wb_stb_o && n_stb < 20) begin
            n_stb++;
            tick();
        end
        check("tmo_stb_cycles", 64'(n_stb),    64'(4));
        check("tmo_rvalid",     64'(s_rvalid), 64'(1));
        check("tmo_rresp",      64'(s_rresp),  64'(2'b11));
        check("tmo_rdata",      64'(s_rdata),  64'(0));
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;

        // Normal write after the timeout
        s_awaddr  = 32'h0000_6000;
        s_awvalid = 1'b1;
        s_wdata   = 32'h1122_3344;
        s_wstrb   = 4'hC;
        s_wvalid  = 1'b1;
        tick();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        tick();
        check("w3_cyc", 64'(wb_cyc_o), 64'(1));
        check("w3_adr", 64'(wb_adr_o), 64'(32'h0000_6000));
        check("w3_sel", 64'(wb_sel_o), 64'(4'hC));
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("w3_bvalid", 64'(s_bvalid), 64'(1));
        check("w3_bresp",  64'(s_bresp),  64'(2'b00));
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;

        // ---------------- all valids held: reads and writes alternate ----------------
        // The previous access was a write, so the first transaction is a read.
        s_awaddr  = 32'h0000_7000;
        s_wdata   = 32'h5555_AAAA;
        s_wstrb   = 4'hF;
        s_araddr  = 32'h0000_8000;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_arvalid = 1'b1;
        s_bready  = 1'b1;
        s_rready  = 1'b1;
        wb_dat_i  = 32'h0BAD_0BAD;
        n_tx      = 0;
        prev_cyc  = 1'b0;
        done      = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            if (wb_cyc_o && !prev_cyc) begin
                if (n_tx < 6) order[n_tx] = wb_we_o;
                n_tx++;
            end
            prev_cyc = wb_cyc_o;
            if (n_tx == 7 && wb_cyc_o) begin
                done = 1'b1;
            end else begin
                wb_ack_i = wb_cyc_o;
            end
        end
        check("alt_reached_7", 64'(done), 64'(1));
        check("alt_tx0_read",  64'(order[0]), 64'(0));
        check("alt_tx1_write", 64'(order[1]), 64'(1));
        check("alt_tx2_read",  64'(order[2]), 64'(0));
        check("alt_tx3_write", 64'(order[3]), 64'(1));
        check("alt_tx4_read",  64'(order[4]), 64'(0));
        check("alt_tx5_write", 64'(order[5]), 64'(1));
        check("alt_tx6_in_rd", 64'({wb_cyc_o, wb_we_o}), 64'(2'b10));

        // ---------------- reset in the middle of the WB_RD cycle ----------------
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_arvalid = 1'b0;
        wb_ack_i  = 1'b0;
        rst       = 1'b0;
        tick();
        check("mrst_cyc",    64'(wb_cyc_o), 64'(0));
        check("mrst_stb",    64'(wb_stb_o), 64'(0));
        check("mrst_rvalid", 64'(s_rvalid), 64'(0));
        rst = 1'b1;
        tick();
        check("mrst_no_rvalid", 64'(s_rvalid), 64'(0));
        check("mrst_no_bvalid", 64'(s_bvalid), 64'(0));
        tick();
        check("mrst_no_rvalid2", 64'(s_rvalid), 64'(0));
        check("mrst_cyc_idle",   64'(wb_cyc_o), 64'(0));
        check("mrst_arready",    64'(s_arready), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_to_wb_bridge.md
AXI_LITE_TO_WB_BRIDGE -- requirements
Module: axi_lite_to_wb_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of both ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width of both ports; byte-lane width is DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT, default 255, cycles of stb without termination before abort; 0 disables the timeout.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port s_awaddr  input  ADDR_WIDTH  AXI4-Lite write address.
REQ-007 SHALL have port s_awvalid  input  1  write address valid.
REQ-008 SHALL have port s_awready  output  1  write address ready.
REQ-009 SHALL have port s_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port s_wstrb  input  DATA_WIDTH/8  write byte strobes.
REQ-011 SHALL have port s_wvalid  input  1  write data valid.
REQ-012 SHALL have port s_wready  output  1  write data ready.
REQ-013 SHALL have port s_bresp  output  2  write response code.
REQ-014 SHALL have port s_bvalid  output  1  write response valid.
REQ-015 SHALL have port s_bready  input  1  write response ready.
REQ-016 SHALL have port s_araddr  input  ADDR_WIDTH  read address.
REQ-017 SHALL have port s_arvalid  input  1  read address valid.
REQ-018 SHALL have port s_arready  output  1  read address ready.
REQ-019 SHALL have port s_rdata  output  DATA_WIDTH  read data.
REQ-020 SHALL have port s_rresp  output  2  read response code.
REQ-021 SHALL have port s_rvalid  output  1  read data valid.
REQ-022 SHALL have port s_rready  input  1  read data ready.
REQ-023 SHALL have port wb_cyc_o  output  1  Wishbone cycle.
REQ-024 SHALL have port wb_stb_o  output  1  Wishbone strobe.
REQ-025 SHALL have port wb_we_o  output  1  Wishbone write enable.
REQ-026 SHALL have port wb_adr_o  output  ADDR_WIDTH  Wishbone address, AXI address passed unmodified.
REQ-027 SHALL have port wb_sel_o  output  DATA_WIDTH/8  Wishbone byte select.
REQ-028 SHALL have port wb_dat_o  output  DATA_WIDTH  Wishbone write data.
REQ-029 SHALL have port wb_dat_i  input  DATA_WIDTH  Wishbone read data.
REQ-030 SHALL have port wb_ack_i  input  1  Wishbone normal termination.
REQ-031 SHALL have port wb_err_i  input  1  Wishbone error termination.
REQ-032 SHALL have port wb_rty_i  input  1  Wishbone retry termination.

Function
REQ-033 SHALL implement FSM states IDLE, WB_WR, WB_RD, WR_RESP, RD_RESP; one Wishbone classic transaction outstanding at a time; all outputs registered.
REQ-034 SHALL capture AW and W independently into holding registers in IDLE, in either order or together; awready/wready high only in IDLE while their own register is empty and (fair=0 or arvalid=0).
REQ-035 SHALL assert s_arready only in IDLE with both holding registers empty and (fair=1 or awvalid=wvalid=0); fair is set on write completion and cleared on read completion.
REQ-036 SHALL go IDLE->WB_WR the cycle after both AW and W are held; IDLE->WB_RD the cycle after the AR handshake; cyc=stb=1 from that cycle, with we, adr, sel=wstrb (sel=all ones for reads) and dat_o stable until termination.
REQ-037 SHALL terminate on sampled ack, err or rty, or when TIMEOUT consecutive stb cycles elapse; cyc/stb low the next cycle; err/rty take precedence over ack when coincident.
REQ-038 SHALL map responses: ack -> 2'b00 OKAY; err or rty -> 2'b10 SLVERR; timeout -> 2'b11 DECERR.
REQ-039 SHALL on read termination register wb_dat_i into s_rdata on ack, else 0; s_rvalid rises with cyc drop; hold rdata/rresp/rvalid until rready, then go IDLE.
REQ-040 SHALL on write termination raise s_bvalid with bresp in the cycle cyc drops, hold until bready, then clear holding registers and go IDLE.
REQ-041 SHALL ignore wb_ack_i/err/rty when cyc is low; drive we, sel, dat_o to 0 in IDLE.

Reset
REQ-042 SHALL on rst=0 at a clock edge clear all outputs to 0, empty holding registers, clear fair and the timeout counter, enter IDLE; a reset mid-transaction drops cyc/stb at that edge and issues no AXI response.

Verification
REQ-043 Write 0xDEADBEEF to 0x1000, strb 0xF, AW before W by 3 cycles; ack after 2 stb cycles -> wb sel 0xF, we=1, bresp 00, one bvalid pulse held until bready.
REQ-044 Read 0x2004, slave returns 0x12345678 with ack -> rdata 0x12345678, rresp 00; AR handshake cycle N gives cyc at N+1.
REQ-045 Read with err asserted together with ack -> rresp 10, rdata 0; write with rty -> bresp 10.
REQ-046 TIMEOUT=4, slave never responds -> stb high exactly 4 cycles, then rresp 11; later write completes normally.
REQ-047 awvalid, wvalid and arvalid held continuously -> writes and reads alternate; reset asserted during WB_RD -> cyc low next edge, no rvalid.
